// File: rtl/vc_ingress_router_pkg.sv
// Shared state encodings and default widths for the VC ingress router.
package vc_ingress_router_pkg;
   localparam int DATA_W_DEF    = 6;
   localparam int CLASS_BIT_DEF = 5;
   localparam int CNT_W_DEF     = 5;

   localparam logic [1:0] ST_RESET  = 2'd0;
   localparam logic [1:0] ST_INIT   = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;
   localparam logic [1:0] ST_ACTIVE = 2'd3;
endpackage

// File: rtl/vc_ingress_router_counter.sv
// Per-VC routed-word counter; wraps modulo 2^CNT_WIDTH, clr beats inc.
module vc_word_counter #(
   parameter int CNT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/vc_ingress_router.sv
// Ingress router: pops the input FIFO and steers each word to VC0/VC1 by class bit.
module vc_ingress_router
   import vc_ingress_router_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int CLASS_BIT  = CLASS_BIT_DEF,
   parameter int CNT_WIDTH  = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  init,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_empty,
   output logic                  in_pop,
   input  logic                  VC0_pause,
   input  logic                  VC1_pause,
   input  logic                  VC0_full,
   input  logic                  VC1_full,
   output logic                  VC0_push,
   output logic                  VC1_push,
   output logic [DATA_WIDTH-1:0] VC0_data,
   output logic [DATA_WIDTH-1:0] VC1_data,
   output logic [CNT_WIDTH-1:0]  count_VC0,
   output logic [CNT_WIDTH-1:0]  count_VC1,
   output logic                  error_out,
   output logic                  idle_out,
   output logic [1:0]            state
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_rd_valid;
   logic       w_run;
   logic       w_busy;
   logic       w_push0;
   logic       w_push1;

   // Class is unknown until the word is read, so either pause blocks the pop.
   assign w_run   = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
   assign in_pop  = w_run && !init && !in_empty && !VC0_pause && !VC1_pause;
   assign w_busy  = r_rd_valid || VC0_push || VC1_push;
   assign w_push0 = r_rd_valid && !init && !in_data[CLASS_BIT];
   assign w_push1 = r_rd_valid && !init && in_data[CLASS_BIT];
   assign idle_out = (r_state == ST_IDLE) && !w_busy;
   assign state    = r_state;

   always_comb begin
      w_state_nxt = r_state;
      if (init) begin
         w_state_nxt = ST_INIT;
      end else begin
         case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   w_state_nxt = ST_IDLE;
            ST_IDLE:   if (in_pop) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!in_pop && !w_busy) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state    <= ST_RESET;
         r_rd_valid <= 1'b0;
         VC0_push   <= 1'b0;
         VC1_push   <= 1'b0;
         VC0_data   <= '0;
         VC1_data   <= '0;
         error_out  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= in_pop;
         VC0_push   <= w_push0;
         VC1_push   <= w_push1;
         if (w_push0) VC0_data <= in_data;
         if (w_push1) VC1_data <= in_data;
         // Overflow is judged while the write is on the FIFO port.
         if (init) begin
            error_out <= 1'b0;
         end else if ((VC0_push && VC0_full) || (VC1_push && VC1_full)) begin
            error_out <= 1'b1;
         end
      end
   end

   vc_word_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_vc0 (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (w_push0),
      .clr     (init),
      .count   (count_VC0)
   );

   vc_word_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_vc1 (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (w_push1),
      .clr     (init),
      .count   (count_VC1)
   );

endmodule

// File: tb/tb_vc_ingress_router.sv
// Directed bench for vc_ingress_router with a small input-FIFO model.
module tb_vc_ingress_router;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       init = 1'b0;
   logic [5:0] in_data = '0;
   logic       in_empty;
   logic       in_pop;
   logic       VC0_pause = 1'b0;
   logic       VC1_pause = 1'b0;
   logic       VC0_full = 1'b0;
   logic       VC1_full = 1'b0;
   logic       VC0_push;
   logic       VC1_push;
   logic [5:0] VC0_data;
   logic [5:0] VC1_data;
   logic [4:0] count_VC0;
   logic [4:0] count_VC1;
   logic       error_out;
   logic       idle_out;
   logic [1:0] state;

   int n_chk = 0;
   int n_err = 0;
   int n_push0 = 0;
   int snap;

   logic [5:0] mem [64];
   int rp = 0;
   int wp = 0;

   always #5 clk = ~clk;

   vc_ingress_router dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .init      (init),
      .in_data   (in_data),
      .in_empty  (in_empty),
      .in_pop    (in_pop),
      .VC0_pause (VC0_pause),
      .VC1_pause (VC1_pause),
      .VC0_full  (VC0_full),
      .VC1_full  (VC1_full),
      .VC0_push  (VC0_push),
      .VC1_push  (VC1_push),
      .VC0_data  (VC0_data),
      .VC1_data  (VC1_data),
      .count_VC0 (count_VC0),
      .count_VC1 (count_VC1),
      .error_out (error_out),
      .idle_out  (idle_out),
      .state     (state)
   );

   assign in_empty = (rp == wp);

   always @(posedge clk) begin
      if (in_pop) begin
         in_data <= mem[rp & 63];
         rp      <= rp + 1;
      end
   end

   always @(negedge clk) begin
      if (VC0_push) n_push0 = n_push0 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input logic [5:0] w);
      mem[wp & 63] = w;
      wp = wp + 1;
   endtask

   initial begin
      // reset and init
      step(2);
      check("rst_state", 32'(state), 0);
      check("rst_pop", 32'(in_pop), 0);
      check("rst_idle", 32'(idle_out), 0);
      check("rst_cnt", 32'({count_VC0, count_VC1}), 0);
      reset_L = 1'b1;
      init    = 1'b1;
      step(1);
      check("init_state1", 32'(state), 1);
      step(1);
      check("init_state2", 32'(state), 1);
      check("init_outs", 32'({VC0_push, VC1_push, error_out, idle_out, in_pop}), 0);
      init = 1'b0;
      step(1);
      check("idle_state", 32'(state), 2);
      check("idle_out", 32'(idle_out), 1);

      // routing
      put(6'h05);
      put(6'h25);
      put(6'h12);
      #1;
      check("rt_pop", 32'(in_pop), 1);
      step(1);
      check("rt_active", 32'(state), 3);
      check("rt_nopush", 32'({VC0_push, VC1_push}), 0);
      step(1);
      check("rt_p1", 32'({VC0_push, VC1_push, VC0_data}), {2'b10, 6'h05});
      step(1);
      check("rt_p2", 32'({VC0_push, VC1_push, VC1_data}), {2'b01, 6'h25});
      check("rt_hold0", 32'(VC0_data), 32'h05);
      step(1);
      check("rt_p3", 32'({VC0_push, VC1_push, VC0_data}), {2'b10, 6'h12});
      check("rt_cnt", 32'({count_VC0, count_VC1}), {5'd2, 5'd1});
      step(2);
      check("rt_back_idle", 32'({state, idle_out}), {2'd2, 1'b1});

      // backpressure
      VC1_pause = 1'b1;
      put(6'h01);
      put(6'h22);
      put(6'h03);
      put(6'h24);
      #1;
      check("bp_pop_gated", 32'(in_pop), 0);
      step(3);
      check("bp_nopush", 32'({count_VC0, count_VC1}), {5'd2, 5'd1});
      VC1_pause = 1'b0;
      #1;
      check("bp_resume", 32'(in_pop), 1);
      step(2);
      VC0_pause = 1'b1;
      #1;
      check("bp_pop_gated0", 32'(in_pop), 0);
      step(4);
      check("bp_inflight", 32'({count_VC0, count_VC1}), {5'd3, 5'd2});
      check("bp_still", 32'(in_pop), 0);
      VC0_pause = 1'b0;
      step(6);
      check("bp_drain", 32'({count_VC0, count_VC1}), {5'd4, 5'd3});
      check("bp_idle", 32'(idle_out), 1);

      // overflow
      VC0_full = 1'b1;
      put(6'h0A);
      check("ov_err0", 32'(error_out), 0);
      step(5);
      check("ov_cnt", 32'(count_VC0), 5);
      check("ov_err1", 32'(error_out), 1);
      VC0_full = 1'b0;
      step(2);
      check("ov_sticky", 32'(error_out), 1);
      init = 1'b1;
      step(1);
      check("ov_clr", 32'({error_out, count_VC0, count_VC1}), 0);
      check("ov_init_st", 32'(state), 1);
      init = 1'b0;
      step(1);
      check("ov_idle_st", 32'(state), 2);

      // counter wrap
      for (int i = 0; i < 33; i++) put(6'h20 | 6'(i & 31));
      step(40);
      check("wrap_cnt", 32'({count_VC0, count_VC1}), {5'd0, 5'd1});
      check("wrap_idle", 32'(state), 2);

      // init with words in flight
      for (int i = 1; i <= 5; i++) put(6'(i));
      step(2);
      check("if_cnt_pre", 32'(count_VC0), 1);
      init = 1'b1;
      #1;
      check("if_pop_drop", 32'(in_pop), 0);
      step(1);
      check("if_nopush", 32'({VC0_push, VC1_push}), 0);
      check("if_cnt_clr", 32'({count_VC0, count_VC1}), 0);
      snap = n_push0;
      step(3);
      wp = rp;
      init = 1'b0;
      step(3);
      check("if_no_more", 32'(n_push0 - snap), 0);
      check("if_cnt_end", 32'({count_VC0, count_VC1}), 0);

      // async reset while active
      put(6'h01);
      put(6'h02);
      put(6'h03);
      put(6'h04);
      step(2);
      check("ar_active", 32'({state, VC0_push}), {2'd3, 1'b1});
      #2;
      reset_L = 1'b0;
      #1;
      check("ar_state", 32'(state), 0);
      check("ar_outs", 32'({VC0_push, VC1_push, in_pop, idle_out, error_out}), 0);
      check("ar_cnt", 32'({count_VC0, count_VC1}), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
